// File: rtl/gpio_arbiter.sv
// gpio_arbiter: two-requester round-robin arbiter in front of one shared GPIO block.
//
// Each transaction walks IDLE -> BUSY -> ACK -> IDLE, one cycle in BUSY and one in ACK.
// The GPIO bus is driven only in BUSY. Read data is latched into the owner's rd port
// at the end of BUSY. The owner's ack pulses for the whole ACK cycle.
//
// Optional build macro GPIO_ARB_LOCK_EN: when it is defined, an owner that holds its
// lock input high in the ACK cycle keeps the grant. The other request is then ignored
// until one of that owner's transactions completes with lock low. When the macro is
// not defined, lock0/lock1 are ignored and arbitration is pure round-robin.
//
// Handshake: a requester raises reqi with its we/a/wd stable and holds them until acki
// pulses. acki is the single-cycle completion. A reqi still high in the cycle after the
// ACK cycle is taken as a new request.

module gpio_arbiter #(
    parameter int AW = 2,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] a0,
    input  logic [AW-1:0] a1,
    input  logic [DW-1:0] wd0,
    input  logic [DW-1:0] wd1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rd0,
    output logic [DW-1:0] rd1,
    output logic [AW-1:0] gpio_a,
    output logic          gpio_we,
    output logic [DW-1:0] gpio_wd,
    input  logic [DW-1:0] gpio_rd,
    output logic          owner,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       ptr;        // requester favoured at the next contended grant
    logic       lock_hold;  // grant is pinned to the current owner
    logic       lock_sel;   // owner's lock request as seen in ACK
    logic       grant_vld;
    logic       grant_idx;

`ifdef GPIO_ARB_LOCK_EN
    assign lock_sel = owner ? lock1 : lock0;
`else
    logic unused_lock;
    assign unused_lock = lock0 ^ lock1;
    assign lock_sel    = 1'b0;
`endif

    // Pick the requester to serve when IDLE: a pinned owner first, otherwise round-robin
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = ptr;
        if (lock_hold) begin
            grant_idx = owner;
            grant_vld = owner ? req1 : req0;
        end else if (req0 && req1) begin
            grant_vld = 1'b1;
            grant_idx = ptr;
        end else if (req0) begin
            grant_vld = 1'b1;
            grant_idx = 1'b0;
        end else if (req1) begin
            grant_vld = 1'b1;
            grant_idx = 1'b1;
        end
    end

    // Next-state decode; BUSY and ACK always last exactly one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = grant_vld ? S_BUSY : S_IDLE;
            S_BUSY:  state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Owner, round-robin pointer and lock pinning
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= 1'b0;
            ptr       <= 1'b0;
            lock_hold <= 1'b0;
        end else begin
            if (state == S_IDLE && grant_vld) begin
                owner <= grant_idx;
            end
            if (state == S_ACK) begin
                ptr       <= ~owner;
                lock_hold <= lock_sel;
            end
        end
    end

    // GPIO bus: loaded at grant so it is valid throughout BUSY; we drops after BUSY
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_a  <= '0;
            gpio_we <= 1'b0;
            gpio_wd <= '0;
        end else begin
            if (state == S_IDLE && grant_vld) begin
                gpio_a  <= grant_idx ? a1  : a0;
                gpio_wd <= grant_idx ? wd1 : wd0;
                gpio_we <= grant_idx ? we1 : we0;
            end else begin
                gpio_we <= 1'b0;
            end
        end
    end

    // Read data capture at the end of BUSY, only for the owner and only on reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd0 <= '0;
            rd1 <= '0;
        end else if (state == S_BUSY && !gpio_we) begin
            if (owner) begin
                rd1 <= gpio_rd;
            end else begin
                rd0 <= gpio_rd;
            end
        end
    end

    // Completion pulse for the owner during the ACK cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
        end else begin
            ack0 <= (state == S_BUSY) && !owner;
            ack1 <= (state == S_BUSY) &&  owner;
        end
    end

    assign busy      = (state == S_BUSY) || (state == S_ACK);
    assign dbg_state = state;

endmodule

// File: tb/tb_gpio_arbiter.sv
// Testbench for gpio_arbiter.
// Directed transactions are driven from the main process. For each transaction the
// expected GPIO bus cycle goes into bus_q and the expected completion goes into exp_q.
// A negedge monitor pops and compares those entries whenever the DUT enters BUSY or
// pulses an ack.

module tb_gpio_arbiter;

    localparam int AW = 2;
    localparam int DW = 32;
    localparam int EW = 34;  // {idx, we, rd_value}
    localparam int BW = 35;  // {we, a, wd}

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [DW-1:0] wd0 = '0, wd1 = '0;
    logic          lock0 = 1'b0, lock1 = 1'b0;
    logic          ack0, ack1, gpio_we, owner, busy;
    logic [DW-1:0] rd0, rd1, gpio_wd;
    logic [DW-1:0] gpio_rd = '0;
    logic [AW-1:0] gpio_a;
    logic [1:0]    dbg_state;

    logic [EW-1:0] exp_q[$];
    logic [BW-1:0] bus_q[$];
    logic [DW-1:0] rd_m[2];
    int            total = 0;
    int            bad = 0;
    int            we_cnt = 0;
    logic          busy_prev = 1'b0;

    gpio_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .a0(a0), .a1(a1), .wd0(wd0), .wd1(wd1),
        .lock0(lock0), .lock1(lock1),
        .ack0(ack0), .ack1(ack1), .rd0(rd0), .rd1(rd1),
        .gpio_a(gpio_a), .gpio_we(gpio_we), .gpio_wd(gpio_wd), .gpio_rd(gpio_rd),
        .owner(owner), .busy(busy), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ack0"}, 64'(ack0), 64'd0);
        check({tag, "_ack1"}, 64'(ack1), 64'd0);
        check({tag, "_rd0"}, 64'(rd0), 64'd0);
        check({tag, "_rd1"}, 64'(rd1), 64'd0);
        check({tag, "_gpio_a"}, 64'(gpio_a), 64'd0);
        check({tag, "_gpio_we"}, 64'(gpio_we), 64'd0);
        check({tag, "_gpio_wd"}, 64'(gpio_wd), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_owner"}, 64'(owner), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    task automatic clear_inputs();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        a0 = '0; a1 = '0; wd0 = '0; wd1 = '0;
        lock0 = 1'b0; lock1 = 1'b0;
    endtask

    // Full reset: two cycles with rst high, values checked before release
    task automatic do_reset(input string tag);
        rst = 1'b1;
        clear_inputs();
        exp_q.delete();
        bus_q.delete();
        rd_m[0] = '0;
        rd_m[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals(tag);
        rst = 1'b0;
    endtask

    // Wait for n acks; check latency of the first and spacing of the rest
    task automatic wait_acks(input int n, input int first_lat, input int spacing, input string tag);
        int cyc = 0;
        int seen = 0;
        int last = 0;
        while (seen < n && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ack0 || ack1) begin
                seen++;
                if (seen == 1) check({tag, "_lat"}, 64'(cyc), 64'(first_lat));
                else if (spacing > 0) check({tag, "_gap"}, 64'(cyc - last), 64'(spacing));
                last = cyc;
            end
        end
        if (seen < n) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d acks want %0d", tag, seen, n);
        end
    endtask

    // Monitor: compares GPIO bus on entry to BUSY and completions on each ack
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [BW-1:0] b;
        if (rst) begin
            busy_prev = 1'b0;
        end else begin
            if (ack0 && ack1) check("ack_both", 64'd1, 64'd0);
            if (ack0 || ack1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b want none", ack0, ack1);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_idx", 64'(ack1), 64'(e[33]));
                    check("owner", 64'(owner), 64'(e[33]));
                    if (!e[32]) rd_m[e[33]] = e[31:0];
                    check("rd0", 64'(rd0), 64'(rd_m[0]));
                    check("rd1", 64'(rd1), 64'(rd_m[1]));
                end
            end
            if (busy && !busy_prev) begin
                if (bus_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_grant: got busy=1 want idle");
                end else begin
                    b = bus_q.pop_front();
                    check("gpio_we", 64'(gpio_we), 64'(b[34]));
                    check("gpio_a", 64'(gpio_a), 64'(b[33:32]));
                    check("gpio_wd", 64'(gpio_wd), 64'(b[31:0]));
                end
            end else if (gpio_we) begin
                total++;
                bad++;
                $display("FAIL stray_we: got gpio_we=1 outside BUSY want 0");
            end
            if (gpio_we) we_cnt++;
            busy_prev = busy;
        end
    end

    initial begin
        int we_before;

        // Reset state
        do_reset("rst0");

        // Single read by requester 0
        we_before = we_cnt;
        gpio_rd = 32'h0000_00A5;
        we0 = 1'b0; a0 = 2'd0; wd0 = 32'h0;
        exp_q.push_back({1'b0, 1'b0, 32'h0000_00A5});
        bus_q.push_back({1'b0, 2'd0, 32'h0});
        req0 = 1'b1;
        wait_acks(1, 2, 0, "rd");
        req0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rd_strobes", 64'(we_cnt - we_before), 64'd0);
        check("rd_idle", 64'(busy), 64'd0);

        // Single write by requester 1
        we_before = we_cnt;
        gpio_rd = 32'h1111_2222;
        we1 = 1'b1; a1 = 2'd2; wd1 = 32'hDEAD_BEEF;
        exp_q.push_back({1'b1, 1'b1, 32'h0});
        bus_q.push_back({1'b1, 2'd2, 32'hDEAD_BEEF});
        req1 = 1'b1;
        wait_acks(1, 2, 0, "wr");
        req1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("wr_strobes", 64'(we_cnt - we_before), 64'd1);
        check("wr_gpio_a_hold", 64'(gpio_a), 64'd2);
        check("wr_gpio_wd_hold", 64'(gpio_wd), 64'hDEAD_BEEF);

        // Reset in the middle of BUSY aborts the read
        we_before = we_cnt;
        gpio_rd = 32'h0000_0077;
        we0 = 1'b0; a0 = 2'd3; wd0 = 32'h0000_0003;
        exp_q.push_back({1'b0, 1'b0, 32'h0000_0077});
        bus_q.push_back({1'b0, 2'd3, 32'h0000_0003});
        req0 = 1'b1;
        @(posedge clk);
        #7;
        check("mid_state_busy", 64'(dbg_state), 64'd1);
        rst = 1'b1;
        clear_inputs();
        exp_q.delete();
        rd_m[0] = '0;
        rd_m[1] = '0;
        #1;
        check_reset_vals("mid");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("mid_no_ack", 64'(ack0 | ack1), 64'd0);
            check("mid_no_we", 64'(gpio_we), 64'd0);
        end
        check("mid_strobes", 64'(we_cnt - we_before), 64'd0);

        // Contention from reset: grants 0,1,0,1 with acks every 3 cycles
        do_reset("rst1");
        gpio_rd = 32'h1234_5678;
        we0 = 1'b0; a0 = 2'd2; wd0 = 32'h0;
        we1 = 1'b1; a1 = 2'd1; wd1 = 32'h0BAD_F00D;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({1'b0, 1'b0, 32'h1234_5678});
            bus_q.push_back({1'b0, 2'd2, 32'h0});
            exp_q.push_back({1'b1, 1'b1, 32'h0});
            bus_q.push_back({1'b1, 2'd1, 32'h0BAD_F00D});
        end
        req0 = 1'b1;
        req1 = 1'b1;
        wait_acks(4, 2, 3, "rr");
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(posedge clk);

        // Lock: requester 0 holds lock for its first transaction only
        do_reset("rst2");
        gpio_rd = 32'hCAFE_0001;
        we0 = 1'b0; a0 = 2'd0; wd0 = 32'h0;
        we1 = 1'b1; a1 = 2'd3; wd1 = 32'h55AA_55AA;
        exp_q.push_back({1'b0, 1'b0, 32'hCAFE_0001});
        bus_q.push_back({1'b0, 2'd0, 32'h0});
`ifdef GPIO_ARB_LOCK_EN
        exp_q.push_back({1'b0, 1'b0, 32'hCAFE_0001});
        bus_q.push_back({1'b0, 2'd0, 32'h0});
        exp_q.push_back({1'b1, 1'b1, 32'h0});
        bus_q.push_back({1'b1, 2'd3, 32'h55AA_55AA});
`else
        exp_q.push_back({1'b1, 1'b1, 32'h0});
        bus_q.push_back({1'b1, 2'd3, 32'h55AA_55AA});
        exp_q.push_back({1'b0, 1'b0, 32'hCAFE_0001});
        bus_q.push_back({1'b0, 2'd0, 32'h0});
`endif
        lock0 = 1'b1;
        req0 = 1'b1;
        req1 = 1'b1;
        wait_acks(1, 2, 0, "lk1");
        @(posedge clk);
        #1;
        lock0 = 1'b0;
        wait_acks(2, 2, 3, "lk2");
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("bus_q_drained", 64'(bus_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
